// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
`timescale 1ns/1ps
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell.
`timescale 1ns/1ps
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock through a single fulladder,
// with the carry kept in a flop between bits.
`timescale 1ns/1ps
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  fulladder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (fa_s),
    .c   (fa_c)
  );

  // Sum bits enter at the MSB so the LSB-first result lands in place after WIDTH shifts.
  always_comb begin
    res_next            = res >> 1;
    res_next[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          res   <= res_next;
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          // Last bit: publish the result on the same edge it completes.
          if (cnt == LAST) begin
            sum   <= res_next;
            cout  <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
`timescale 1ns/1ps
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done;
  logic [7:0] sum;
  logic       cout;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy1, done1;
  logic [0:0] sum1;
  logic       cout1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One operation with a single-cycle start pulse; returns result and timing.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       output logic [7:0] rs, output logic rc,
                       output int edges, output int busyc, output bit held);
    logic [7:0] prev_s;
    logic       prev_c;
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    prev_s = sum; prev_c = cout;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1; busyc = 0; held = 1'b1;
    while (!done && edges < 30) begin
      if (busy) busyc++;
      if (sum !== prev_s || cout !== prev_c) held = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    rs = sum; rc = cout;
  endtask

  logic [7:0] rs;
  logic       rc;
  int         edges, busyc, gap, last_done;
  bit         held, ok;
  logic [8:0] ref_v;
  logic [7:0] ops_a[6], ops_b[6];
  logic       ops_c[6];

  initial begin
    tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #12;
    chk("reset_out", {busy, done, cout, sum}, 32'h0);
    chk("reset_out_w1", {busy1, done1, cout1, sum1}, 32'h0);
    @(negedge clk); reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, rs, rc, edges, busyc, held);
      chk($sformatf("tbl%0d_sum", i), rs, tbl[i].s);
      chk($sformatf("tbl%0d_cout", i), rc, tbl[i].co);
      chk($sformatf("tbl%0d_edges", i), edges, 9);
      chk($sformatf("tbl%0d_busy", i), busyc, 8);
      chk($sformatf("tbl%0d_held", i), held, 1);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_pulse", i), done, 0);
    end

    // Random operands against plain arithmetic.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      logic       rcin;
      ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + {8'b0, rcin};
      do_op(ra, rb, rcin, rs, rc, edges, busyc, held);
      chk($sformatf("rnd%0d", i), {rc, rs}, ref_v);
    end

    // Start during RUN is ignored; sum holds its prior value until done.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    rs = sum;
    @(posedge clk); #1; @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    edges = 4; ok = 1'b1;
    while (!done && edges < 30) begin
      if (sum !== rs) ok = 1'b0;
      @(posedge clk); #1; edges++;
    end
    chk("ign_edges", edges, 9);
    chk("ign_result", {cout, sum}, 9'h030);
    chk("ign_held", ok, 1);

    // Back-to-back with start held high.
    for (int i = 0; i < 6; i++) begin
      ops_a[i] = (i % 2) ? 8'hC3 + 8'(i) : 8'h3C + 8'(i);
      ops_b[i] = (i % 2) ? 8'h7E : 8'h81 + 8'(i);
      ops_c[i] = 1'(i);
    end
    @(negedge clk);
    a = ops_a[0]; b = ops_b[0]; cin = ops_c[0]; start = 1'b1;
    @(posedge clk); #1;
    a = ops_a[1]; b = ops_b[1]; cin = ops_c[1];
    gap = 1; last_done = -1;
    for (int k = 0; k < 4; k++) begin
      while (!done && gap < 40) begin
        @(posedge clk); #1; gap++;
      end
      ref_v = {1'b0, ops_a[k]} + {1'b0, ops_b[k]} + {8'b0, ops_c[k]};
      chk($sformatf("b2b%0d_result", k), {cout, sum}, ref_v);
      chk($sformatf("b2b%0d_gap", k), gap, (k == 0) ? 9 : 9);
      @(posedge clk); #1;
      gap = 1;
      a = ops_a[k+2]; b = ops_b[k+2]; cin = ops_c[k+2];
    end
    start = 1'b0;
    edges = 0;
    while (!done && edges < 30) begin
      @(posedge clk); #1; edges++;
    end
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN.
    chk("pre_rst_sum_nonzero", (sum != 0) || cout, 1);
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk("arst_out", {busy, done, cout, sum}, 32'h0);
    @(negedge clk); reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) ok = 1'b0;
    end
    chk("arst_no_done", ok, 1);
    do_op(8'h01, 8'h01, 1'b0, rs, rc, edges, busyc, held);
    chk("arst_fresh", {rc, rs}, 9'h002);
    chk("arst_fresh_edges", edges, 9);

    // WIDTH=1 exhaustive.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      edges = 1; busyc = 0;
      while (!done1 && edges < 10) begin
        if (busy1) busyc++;
        @(posedge clk); #1; edges++;
      end
      chk($sformatf("w1_%0d_result", i), {cout1, sum1}, 32'(v[2] + v[1] + v[0]));
      chk($sformatf("w1_%0d_edges", i), edges, 2);
      chk($sformatf("w1_%0d_busy", i), busyc, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that adds two WIDTH-bit operands one bit per clock through a single instance of the existing `fulladder` cell, with the carry held in a flop between bits. It sits directly upstream of `fulladder`: it sequences operand bits and the carry into it and collects `s`/`c` back into a result register. Operands are loaded with a start pulse, and completion is flagged with a one-cycle done pulse.

## Interface
- `WIDTH`, default 8: operand and result width, ≥1.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: load request; sampled on a rising edge while in IDLE or DONE.
- `a` in WIDTH: operand A; captured when start is accepted.
- `b` in WIDTH: operand B; captured when start is accepted.
- `cin` in 1: carry-in; captured when start is accepted.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse; sum/cout are valid in this cycle.
- `sum` out WIDTH: result; holds its value until the next completion.
- `cout` out 1: final carry-out; holds its value like sum.

## Operation
- FSM states are IDLE, RUN and DONE. Reset puts the FSM in IDLE.
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0. Internal shift registers, carry flop and bit counter are also 0.
- IDLE/DONE with `start`=1:
  - Load `a`, `b` into operand shift registers and `cin` into the carry flop.
  - Clear the bit counter and go to RUN.
- IDLE with `start`=0: stay in IDLE.
- DONE with `start`=0: go to IDLE.
- RUN, each cycle:
  - The `fulladder` inputs are the operand register LSBs and the carry flop.
  - On the edge, shift both operand registers right by one.
  - Shift `s` into the MSB of the internal result shift register.
  - Load `c` into the carry flop and increment the counter.
- RUN exit: on the edge where the counter reaches WIDTH-1, the next state is DONE. Also on that edge, copy the completed result shift value into `sum` and the final `c` into `cout`.
- DONE lasts exactly one cycle: `done`=1 and `busy`=0.
- `start` during RUN is ignored; operands are not re-sampled.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, exact (WIDTH+1 bits), with no overflow flag.
- `sum`/`cout` never change except on the completion edge or on reset. During RUN they show the previous result.

## Timing
- The edge accepting `start` is E0. RUN occupies the cycles after E0 through E(WIDTH).
- `done`=1 in the cycle after edge E(WIDTH), so latency is WIDTH+1 edges from start to done.
- `busy` is high for exactly WIDTH cycles per operation.
- Back-to-back operation: `start` held high during DONE is accepted. The next operation then starts immediately, giving a throughput of one result per WIDTH+1 cycles.
- Reset asserted mid-RUN:
  - Outputs go to their reset values immediately, without waiting for an edge.
  - The operation is abandoned and no `done` is produced.
  - After reset deasserts, the first edge with `start`=1 begins a fresh operation.
- WIDTH=1: RUN lasts one cycle and `done` appears 2 edges after start.

## Structure
- Package `serial_adder_pkg` holds:
  - the state typedef (IDLE, RUN, DONE);
  - a counter-width constant function equal to $clog2(WIDTH) with a minimum of 1.
- One sub-module: the existing `fulladder` (ports `a`, `b`, `cin`, `s`, `c`), instantiated once. No other hierarchy.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x33, `cin`=0, one-cycle start: `busy` is high for 8 cycles, then `done`=1 on the 9th edge after start, with `sum`=0x8D and `cout`=0.
- `a`=0xFF, `b`=0x01, `cin`=0: `sum`=0x00, `cout`=1. Then `a`=0xFF, `b`=0xFF, `cin`=1: `sum`=0xFF, `cout`=1.
- Start 0x10+0x20, then pulse `start` with 0xAA+0x55 at the 3rd RUN cycle: the pulse is ignored and the result is `sum`=0x30, `cout`=0. `sum` keeps its prior value until the done cycle.
- Hold `start` high continuously with alternating operands: `done` pulses every 9 cycles, and each result matches its operands.
- Assert `reset` mid-RUN, asynchronously between edges: `busy`, `done`, `sum` and `cout` go to 0 immediately, and no `done` follows. A fresh operation, 0x01+0x01, then gives 0x02.
- WIDTH=1 build, exhaustive over `a`, `b`, `cin`: {`cout`,`sum`} matches the full-adder truth table, and `done` comes 2 edges after start.
